// File: rtl/v2f_seq_divmod.sv
// Sequential signed/unsigned divider/modulo built from 16-bit limb arithmetic.
// Latency: WIDTH/STEPS + 2 cycles from accept to out_valid, independent of operands.
// Backpressure: one op in flight; in_ready only in IDLE, results held while out_ready is low.
module v2f_seq_divmod #(
    parameter int WIDTH = 64,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div0
);

    localparam int N  = WIDTH / STEPS;
    localparam int CW = $clog2(N + 1);
    localparam int NL = WIDTH / 16;

    typedef enum logic [1:0] {IDLE, RUN, FIX, OUT} state_t;

    // Two's-complement negate, rippling a carry through 16-bit limbs.
    function automatic logic [WIDTH-1:0] limb_neg(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        logic             c;
        logic [16:0]      s;
        y = '0;
        c = 1'b1;
        s = '0;
        for (int i = 0; i < NL; i++) begin
            s             = {1'b0, ~x[i*16 +: 16]} + {16'd0, c};
            y[i*16 +: 16] = s[15:0];
            c             = s[16];
        end
        return y;
    endfunction

    // (WIDTH+1)-bit trial subtract x - y in 16-bit limbs; the MSB of the result
    // is the no-borrow flag (x >= y), the rest is the low WIDTH bits of x - y.
    // The top limb only carries the single spill bit of x, y is zero there.
    function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0]   x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        logic             c;
        logic [16:0]      s;
        d = '0;
        c = 1'b1;
        s = '0;
        for (int i = 0; i < NL; i++) begin
            s             = {1'b0, x[i*16 +: 16]} + {1'b0, ~y[i*16 +: 16]} + {16'd0, c};
            d[i*16 +: 16] = s[15:0];
            c             = s[16];
        end
        s = {16'd0, x[WIDTH]} + 17'h0FFFF + {16'd0, c};
        c = s[16];
        return {c, d};
    endfunction

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] rem;    // partial remainder, always < dvs except when dividing by zero
    logic [WIDTH-1:0] dvs;    // divisor magnitude
    logic             qneg;
    logic             rneg;
    logic             zdiv;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH-1:0] work_n;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Operand sign detection and magnitudes, only meaningful in signed mode.
    always_comb begin
        a_neg = signed_op & a[WIDTH-1];
        b_neg = signed_op & b[WIDTH-1];
        a_mag = a_neg ? limb_neg(a) : a;
        b_mag = b_neg ? limb_neg(b) : b;
    end

    // STEPS restoring shift-subtract iterations, MSB first.
    always_comb begin
        rem_n   = rem;
        work_n  = work;
        shifted = '0;
        trial   = '0;
        for (int k = 0; k < STEPS; k++) begin
            shifted = {rem_n, work_n[WIDTH-1]};
            trial   = trial_sub(shifted, dvs);
            rem_n   = trial[WIDTH] ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            work_n  = {work_n[WIDTH-2:0], trial[WIDTH]};
        end
    end

    // Control FSM with registered handshake and result outputs.
    // RUN spends one extra cycle at cnt == 0 before moving to FIX, so the total
    // latency is N stepping cycles + the exit cycle + the FIX cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            rem       <= '0;
            dvs       <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            zdiv      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= a_mag;
                        dvs      <= b_mag;
                        rem      <= '0;
                        qneg     <= a_neg ^ b_neg;
                        rneg     <= a_neg;
                        zdiv     <= (b == '0);
                        cnt      <= CW'(N);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        work <= work_n;
                        rem  <= rem_n;
                        cnt  <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    // Divide-by-zero reports all-ones regardless of sign; the
                    // remainder magnitude equals |A| so the sign fix restores A.
                    q         <= zdiv ? '1 : (qneg ? limb_neg(work) : work);
                    r         <= rneg ? limb_neg(rem) : rem;
                    div0      <= zdiv;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
